// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing constants and types.
// Holds the DMG defaults (456 dots per line, 154 lines, 144 visible lines),
// the line_cnt width, the Y-driver pin bundle and a counter-width helper.
// The generator, the Y-driver wrappers and the bench all import it, so they
// agree on these values.
package lcd_timing_pkg;

  localparam int unsigned DMG_DOTS_PER_LINE   = 456;
  localparam int unsigned DMG_LINES_PER_FRAME = 154;
  localparam int unsigned DMG_VISIBLE_LINES   = 144;
  localparam int unsigned LINE_CNT_W          = 8;

  // Pins handed to the Y-driver control stage.
  typedef struct packed {
    logic s;
    logic cpl;
    logic fr;
  } ydrv_pins_t;

  // Bits needed to count 0..modulus-1. This is never less than one bit, so
  // a modulus-1 counter stays legal.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/lcd_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and a wrap flag.
// Ports: clk, rst_n (async active-low), en (advance), clr (sync clear, wins),
//        count (registered value), count_nxt_c (value after this edge),
//        wrap_c (this edge takes count from MODULUS-1 back to 0).
module lcd_mod_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned WIDTH   = cnt_width(MODULUS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt_c,
  output logic             wrap_c
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  if (MODULUS < 1 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("lcd_mod_counter: MODULUS does not fit in WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;

  // Next-count decode. Clear has priority over counting.
  always_comb begin
    wrap_c  = en && !clr && (count_q == LAST);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wrap_c) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/lcd_ydriver_timing_gen.sv
// S / CPL / FR pin generator for the LCD row (Y) driver control stage.
// Ports: CLK (dot clock), nRST (async active-low), lcd_on (enable; low parks
//        every pin low and clears the counters),
//        S (frame start shift data), CPL (line clock), FR (polarity reversal),
//        line_cnt (current line), vblank (line_cnt >= VISIBLE_LINES),
//        frame_start (one-cycle pulse at line 0, dot 0).
// Every output is a flop. It is loaded from a decode of the counters' next
// value, so each output changes on the same edge as the counter value it
// describes.
module lcd_ydriver_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned DOTS_PER_LINE   = DMG_DOTS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DMG_LINES_PER_FRAME,
  parameter int unsigned VISIBLE_LINES   = DMG_VISIBLE_LINES,
  parameter int unsigned CPL_START       = 4,
  parameter int unsigned CPL_WIDTH       = 2,
  parameter int unsigned S_HOLD          = 2,
  parameter int unsigned FR_PERIOD       = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  lcd_on,
  output logic                  S,
  output logic                  CPL,
  output logic                  FR,
  output logic [LINE_CNT_W-1:0] line_cnt,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int unsigned DOT_W   = cnt_width(DOTS_PER_LINE);
  localparam int unsigned FR_W    = cnt_width(FR_PERIOD);
  localparam int unsigned CPL_END = CPL_START + CPL_WIDTH;
  localparam int unsigned S_END   = CPL_START + CPL_WIDTH + S_HOLD;

  if (S_END >= DOTS_PER_LINE) begin : g_bad_dot_params
    $error("lcd_ydriver_timing_gen: CPL_START+CPL_WIDTH+S_HOLD must be < DOTS_PER_LINE");
  end
  if (VISIBLE_LINES >= LINES_PER_FRAME || LINES_PER_FRAME > 256) begin : g_bad_line_params
    $error("lcd_ydriver_timing_gen: need VISIBLE_LINES < LINES_PER_FRAME <= 256");
  end
  if (CPL_WIDTH < 1 || FR_PERIOD < 1) begin : g_bad_width_params
    $error("lcd_ydriver_timing_gen: CPL_WIDTH and FR_PERIOD must be >= 1");
  end

  logic                  run_q, run_d;
  logic                  cnt_en_c, cnt_clr_c;
  logic [DOT_W-1:0]      dot_q, dot_nxt_c;
  logic                  dot_wrap_c;
  logic [LINE_CNT_W-1:0] line_q, line_nxt_c;
  logic                  line_wrap_c;
  logic [FR_W-1:0]       fr_cnt_q, fr_cnt_nxt_c;
  logic                  fr_wrap_c;
  ydrv_pins_t            pins_q, pins_d;
  logic                  vblank_q, vblank_d;
  logic                  frame_start_q, frame_start_d;
  logic                  unused_c;

  // The first enabled edge holds the counters at 0 so that dot 0 of line 0
  // is the first cycle shown. Counting starts on the edge after that.
  always_comb begin
    cnt_en_c  = lcd_on & run_q;
    cnt_clr_c = ~lcd_on;
  end

  lcd_mod_counter #(
    .MODULUS (DOTS_PER_LINE),
    .WIDTH   (DOT_W)
  ) u_dot_cnt (
    .clk         (CLK),
    .rst_n       (nRST),
    .en          (cnt_en_c),
    .clr         (cnt_clr_c),
    .count       (dot_q),
    .count_nxt_c (dot_nxt_c),
    .wrap_c      (dot_wrap_c)
  );

  lcd_mod_counter #(
    .MODULUS (LINES_PER_FRAME),
    .WIDTH   (LINE_CNT_W)
  ) u_line_cnt (
    .clk         (CLK),
    .rst_n       (nRST),
    .en          (dot_wrap_c),
    .clr         (cnt_clr_c),
    .count       (line_q),
    .count_nxt_c (line_nxt_c),
    .wrap_c      (line_wrap_c)
  );

  // Counts lines modulo FR_PERIOD. It is never cleared at frame start, so
  // FR keeps its cadence across frames.
  lcd_mod_counter #(
    .MODULUS (FR_PERIOD),
    .WIDTH   (FR_W)
  ) u_fr_cnt (
    .clk         (CLK),
    .rst_n       (nRST),
    .en          (dot_wrap_c),
    .clr         (cnt_clr_c),
    .count       (fr_cnt_q),
    .count_nxt_c (fr_cnt_nxt_c),
    .wrap_c      (fr_wrap_c)
  );

  // Collects counter outputs this block does not use.
  assign unused_c = ^{dot_q, line_wrap_c, fr_cnt_nxt_c, fr_wrap_c};

  // Pin decode from the counters' next value. Every pin is low while disabled.
  always_comb begin
    run_d         = lcd_on;
    pins_d        = '0;
    vblank_d      = 1'b0;
    frame_start_d = 1'b0;
    if (lcd_on) begin
      pins_d.cpl    = (line_nxt_c < LINE_CNT_W'(VISIBLE_LINES))
                   && (dot_nxt_c >= DOT_W'(CPL_START))
                   && (dot_nxt_c < DOT_W'(CPL_END));
      pins_d.s      = (line_nxt_c == '0) && (dot_nxt_c < DOT_W'(S_END));
      pins_d.fr     = pins_q.fr ^ (dot_wrap_c && (fr_cnt_q == FR_W'(FR_PERIOD - 1)));
      vblank_d      = (line_nxt_c >= LINE_CNT_W'(VISIBLE_LINES));
      frame_start_d = (line_nxt_c == '0) && (dot_nxt_c == '0);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      run_q         <= 1'b0;
      pins_q        <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      pins_q        <= pins_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign S           = pins_q.s;
  assign CPL         = pins_q.cpl;
  assign FR          = pins_q.fr;
  assign line_cnt    = line_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule
